// File: rtl/hamming_universal_shift_reg.sv
// hamming_universal_shift_reg: SEC-DED protected universal shift register (SISO/SIPO/PISO/PIPO, both directions)
// Storage is a Hamming codeword decoded every cycle; single errors are scrubbed, double errors flagged.
module hamming_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             clr_count,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic [WIDTH-1:0] pipo_out,
    output logic [WIDTH-1:0] reg_data,
    output logic             err_single,
    output logic             err_double,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] dbl_count
);
    function automatic int calc_r(input int w);
        int r;
        r = 1;
        while ((1 << r) < w + r + 1) r++;
        return r;
    endfunction

    localparam int R = calc_r(WIDTH);
    localparam int CODE_W = WIDTH + R + 1;

    function automatic logic [CODE_W-1:0] encode(input logic [WIDTH-1:0] d);
        logic [CODE_W-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int p = 1; p < CODE_W; p++)
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        for (int b = 0; b < R; b++)
            for (int p = 1; p < CODE_W; p++)
                if (((p >> b) & 1) == 1 && p != (1 << b)) c[1 << b] = c[1 << b] ^ c[p];
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] extract(input logic [CODE_W-1:0] c);
        logic [WIDTH-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p < CODE_W; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p];
                k++;
            end
        return d;
    endfunction

    logic [CODE_W-1:0] code_q, code_d, fixed;
    logic [R-1:0]      syn;
    logic              par, single, dbl, load_en, shift;
    logic [WIDTH-1:0]  cd, nd;
    logic              serial_q, serial_d, single_q, double_q, double_d;
    logic [WIDTH-1:0]  par_q, par_d, pipo_q, pipo_d;
    logic [CNT_W-1:0]  corr_q, corr_d, dblc_q, dblc_d;

    // Syndrome 0 with odd overall parity means the parity bit itself flipped.
    always_comb begin
        syn = '0;
        for (int p = 1; p < CODE_W; p++) if (code_q[p]) syn = syn ^ R'(p);
        par = ^code_q;
        fixed = code_q;
        for (int p = 0; p < CODE_W; p++) if (par && syn == R'(p)) fixed[p] = ~fixed[p];
    end

    assign single  = par;
    assign dbl     = !par && syn != '0;
    assign cd      = extract(fixed);
    assign load_en = enable && load && mode[1];
    assign shift   = enable && !load_en;

    always_comb begin
        nd       = !enable ? cd : load_en ? parallel_in :
                   dir ? {serial_in, cd[WIDTH-1:1]} : {cd[WIDTH-2:0], serial_in};
        code_d   = (enable || single) ? encode(nd) : code_q;
        serial_d = (shift && !mode[0]) ? (dir ? cd[0] : cd[WIDTH-1]) : serial_q;
        par_d    = (enable && mode == 2'b01) ? nd : par_q;
        pipo_d   = (enable && mode == 2'b11) ? nd : pipo_q;
        double_d = load_en ? 1'b0 : dbl ? 1'b1 : enable ? 1'b0 : double_q;
        corr_d   = clr_count ? '0 : (single && corr_q != '1) ? corr_q + 1'b1 : corr_q;
        dblc_d   = clr_count ? '0 : (double_d && !double_q && dblc_q != '1) ? dblc_q + 1'b1 : dblc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q   <= '0;
            serial_q <= 1'b0;
            par_q    <= '0;
            pipo_q   <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            corr_q   <= '0;
            dblc_q   <= '0;
        end else begin
            code_q   <= code_d;
            serial_q <= serial_d;
            par_q    <= par_d;
            pipo_q   <= pipo_d;
            single_q <= single;
            double_q <= double_d;
            corr_q   <= corr_d;
            dblc_q   <= dblc_d;
        end
    end

    assign serial_out   = serial_q;
    assign parallel_out = par_q;
    assign pipo_out     = pipo_q;
    assign reg_data     = cd;
    assign err_single   = single_q;
    assign err_double   = double_q;
    assign corr_count   = corr_q;
    assign dbl_count    = dblc_q;
endmodule
